// File: rtl/reg_file_if.sv
// Register file port bundle: two read ports, one write port, busy.
// master = core side (drives indices/write), slave = register file.
interface reg_file_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] rs1_addr_i;
   logic [ADDR_W-1:0] rs2_addr_i;
   logic [XLEN-1:0]   rs1_data_o;
   logic [XLEN-1:0]   rs2_data_o;
   logic              rd_we_i;
   logic [ADDR_W-1:0] rd_addr_i;
   logic [XLEN-1:0]   rd_data_i;
   logic              busy_o;

   modport master (
      output rs1_addr_i, rs2_addr_i,
      output rd_we_i, rd_addr_i, rd_data_i,
      input  rs1_data_o, rs2_data_o, busy_o
   );

   modport slave (
      input  rs1_addr_i, rs2_addr_i,
      input  rd_we_i, rd_addr_i, rd_data_i,
      output rs1_data_o, rs2_data_o, busy_o
   );
endinterface

// File: rtl/reg_file.sv
// RV32 integer register file, 2 combinational reads, 1 write, x0 = 0.
// Ports: clk_i, rst_i (sync, active-high), bus (reg_file_if.slave):
//   rs1/rs2_addr_i -> rs1/rs2_data_o, rd_we_i/rd_addr_i/rd_data_i,
//   busy_o high while the post-reset clear sweep runs.
// Option: REGFILE_BYPASS_EN enables same-cycle write-through on reads.
module reg_file #(
   parameter int  XLEN     = 32,
   parameter int  NUM_REGS = 32,
   localparam int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic         clk_i,
   input  logic         rst_i,
   reg_file_if.slave    bus
);

   typedef enum logic {
      CLEAR,
      READY
   } state_e;

   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_REGS-1);
   localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

   state_e            state_q;
   logic [ADDR_W:0]   clr_idx_q;
   logic              busy_q;
   logic [XLEN-1:0]   regs_q [NUM_REGS];

   logic              wr_en_d;
   logic [ADDR_W-1:0] wr_addr_d;
   logic [XLEN-1:0]   wr_data_d;
   logic              rd_ok;

   // Sweep controller. clr_idx carries an extra bit so the
   // terminal count is an explicit compare, not a wrap.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= CLEAR;
         clr_idx_q <= '0;
         busy_q    <= 1'b1;
      end else begin
         unique case (state_q)
            CLEAR: begin
               clr_idx_q <= clr_idx_q + ONE;
               if (clr_idx_q == LAST_IDX) begin
                  state_q <= READY;
                  busy_q  <= 1'b0;
               end
            end
            READY: begin
               state_q <= READY;
            end
         endcase
      end
   end

   // Architectural write qualifier: READY, enabled, not x0.
   assign rd_ok = !busy_q && bus.rd_we_i &&
                  (bus.rd_addr_i != '0);

   // Single write port shared by sweep and writeback, so the
   // array has no reset and maps onto plain RAM.
   always_comb begin
      wr_en_d   = 1'b0;
      wr_addr_d = bus.rd_addr_i;
      wr_data_d = bus.rd_data_i;
      if (!rst_i) begin
         if (state_q == CLEAR) begin
            wr_en_d   = 1'b1;
            wr_addr_d = clr_idx_q[ADDR_W-1:0];
            wr_data_d = '0;
         end else begin
            wr_en_d   = rd_ok;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en_d) begin
         regs_q[wr_addr_d] <= wr_data_d;
      end
   end

   function automatic logic [XLEN-1:0] rd_port(
      input logic [ADDR_W-1:0] a
   );
      logic [XLEN-1:0] v;
      v = '0;
      if (!busy_q && (a != '0)) begin
`ifdef REGFILE_BYPASS_EN
         if (rd_ok && (a == bus.rd_addr_i)) begin
            v = bus.rd_data_i;
         end else begin
            v = regs_q[a];
         end
`else
         v = regs_q[a];
`endif
      end
      return v;
   endfunction

   assign bus.rs1_data_o = rd_port(bus.rs1_addr_i);
   assign bus.rs2_data_o = rd_port(bus.rs2_addr_i);
   assign bus.busy_o     = busy_q;

endmodule
